// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, opcodes and mux/ALU select codes.
// MAIN_FSM_ILLEGAL_TRAP_EN adds the TRAP state to the enum.
package main_fsm_pkg;

   localparam int unsigned OP_W  = 7;
   localparam int unsigned SEL_W = 2;

   localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
   localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
   localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   localparam logic [SEL_W-1:0] IMM_I = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_t;

endpackage

// File: rtl/main_fsm_imm_src_decoder.sv
// Immediate-format select decoded straight from the opcode.
module imm_src_decoder
   import main_fsm_pkg::*;
(
   input  logic [OP_W-1:0]  op,
   output logic [SEL_W-1:0] imm_src
);

   always_comb begin
      imm_src = IMM_I;
      case (op)
         OP_SW:   imm_src = IMM_S;
         OP_BEQ:  imm_src = IMM_B;
         OP_JAL:  imm_src = IMM_J;
         default: imm_src = IMM_I;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM (Moore; PCWrite also uses Zero, ImmSrc uses op).
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap on undecoded opcodes instead of refetching.
module main_fsm
   import main_fsm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  op,
   input  logic             Zero,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic [SEL_W-1:0] ResultSrc,
   output logic [SEL_W-1:0] ALUSrcA,
   output logic [SEL_W-1:0] ALUSrcB,
   output logic [SEL_W-1:0] ALUOp,
   output logic [SEL_W-1:0] ImmSrc,
   output logic             Illegal
);

   state_t state, state_nxt;
   logic   pc_update, branch, irwrite_c, regwrite_c, memwrite_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pc_update  = 1'b0;
      branch     = 1'b0;
      irwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      memwrite_c = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUOp      = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            irwrite_c = 1'b1;
            pc_update = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXECUTER;
               OP_ITYPE:     state_nxt = S_EXECUTEI;
               OP_BEQ:       state_nxt = S_BEQ;
               OP_JAL:       state_nxt = S_JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
               default:      state_nxt = S_TRAP;
`else
               default:      state_nxt = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_IMM;
            state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc    = 1'b1;
            state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            regwrite_c = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            memwrite_c = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA   = SRCA_RS1;
            ALUOp     = ALUOP_FUNCT;
            state_nxt = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = SRCB_IMM;
            ALUOp     = ALUOP_FUNCT;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_c = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA   = SRCA_RS1;
            ALUOp     = ALUOP_SUB;
            branch    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
            state_nxt = S_ALUWB;
         end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
         S_TRAP:  state_nxt = S_TRAP;
`endif
         default: state_nxt = S_FETCH;
      endcase
   end

   // Write strobes are suppressed for the whole time reset is held, not only after the state clears.
   assign PCWrite  = ~rst & (pc_update | (branch & Zero));
   assign IRWrite  = ~rst & irwrite_c;
   assign RegWrite = ~rst & regwrite_c;
   assign MemWrite = ~rst & memwrite_c;

   imm_src_decoder u_imm_src_decoder (
      .op      (op),
      .imm_src (ImmSrc)
   );

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     illegal_q <= 1'b0;
      else if (state_nxt == S_TRAP) illegal_q <= 1'b1;
   end

   assign Illegal = illegal_q;
`else
   assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Randomized instruction stream against an instruction-level reference model; scoreboard queue
// filled by the stimulus, drained by a negedge monitor.
module tb_main_fsm;

   typedef struct packed {
      logic       pcw, adr, memw, irw, regw;
      logic [1:0] res, srca, srcb, aluop, imm;
      logic       ill;
   } exp_t;

   typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_t;

   logic       clk = 1'b0;
   logic       rst, Zero;
   logic [6:0] op;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   main_fsm dut (
      .clk(clk), .rst(rst), .op(op), .Zero(Zero),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal)
   );

   function automatic kind_t classify(logic [6:0] o);
      case (o)
         7'b0000011: return K_LW;
         7'b0100011: return K_SW;
         7'b0110011: return K_R;
         7'b0010011: return K_I;
         7'b1100011: return K_BEQ;
         7'b1101111: return K_JAL;
         default:    return K_ILL;
      endcase
   endfunction

   function automatic int latency(logic [6:0] o);
      case (classify(o))
         K_LW:    return 5;
         K_BEQ:   return 3;
         K_ILL:   return 2;
         default: return 4;
      endcase
   endfunction

   // Expected control word for cycle cyc (1-based) of an instruction with opcode o.
   function automatic exp_t model(logic [6:0] o, int cyc, logic z);
      exp_t  e = '0;
      kind_t k = classify(o);
      e.imm = (k == K_SW) ? 2'b01 : (k == K_BEQ) ? 2'b10 : (k == K_JAL) ? 2'b11 : 2'b00;
      if (cyc == 1) begin
         e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
      end else if (cyc == 2) begin
         e.srca = 2'b01; e.srcb = 2'b01;
      end else begin
         case (k)
            K_LW, K_SW: begin
               if (cyc == 3) begin e.srca = 2'b10; e.srcb = 2'b01; end
               else if (cyc == 4) begin e.adr = 1'b1; e.memw = (k == K_SW); end
               else begin e.res = 2'b01; e.regw = 1'b1; end
            end
            K_R, K_I: begin
               if (cyc == 3) begin
                  e.srca = 2'b10; e.aluop = 2'b10; e.srcb = (k == K_I) ? 2'b01 : 2'b00;
               end else e.regw = 1'b1;
            end
            K_BEQ: begin
               e.srca = 2'b10; e.aluop = 2'b01; e.pcw = z;
            end
            K_JAL: begin
               if (cyc == 3) begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
               else e.regw = 1'b1;
            end
            default: e.ill = 1'b1;
         endcase
      end
      return e;
   endfunction

   function automatic exp_t actual();
      return exp_t'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal});
   endfunction

   task automatic check(string name, exp_t got, exp_t want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s op=%b: got %b required %b (pcw adr memw irw regw res srca srcb aluop imm ill)",
                    name, op, got, want);
   endtask

   // zmode 0/1 drives Zero constant, 2 drives it randomly every cycle.
   task automatic run(logic [6:0] o, int ncyc, int zmode);
      op = o;
      for (int c = 1; c <= ncyc; c++) begin
         Zero = (zmode == 2) ? 1'($urandom()) : 1'(zmode);
         q.push_back(model(o, c, Zero));
         @(posedge clk); #1;
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (q.size() > 0) check("cycle", actual(), q.pop_front());
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   initial begin : stim
      exp_t       rv;
      logic [6:0] o;
      logic [6:0] legal [6];
      legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
      rv = '0; rv.srcb = 2'b10; rv.res = 2'b10;

      rst = 1'b1; op = '0; Zero = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("reset_state", actual(), rv);
      rst = 1'b0;

      run(legal[0], 5, 2);
      run(legal[1], 4, 2);
      run(legal[2], 4, 2);
      run(legal[5], 4, 2);
      run(legal[4], 3, 1);
      run(legal[4], 3, 0);
      run(legal[3], 4, 2);

      for (int i = 0; i < 60; i++) begin
         int r = int'($urandom_range(0, 7));
         o = (r < 6) ? legal[r] : 7'($urandom());
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
         if (classify(o) == K_ILL) o = legal[0];
`endif
         run(o, latency(o), 2);
      end

      // Reset asserted in the middle of MEMWB abandons the load.
      run(legal[0], 4, 2);
      q.push_back(model(legal[0], 5, Zero));
      @(negedge clk); #1;
      rst = 1'b1;
      #1 check("rst_async", actual(), rv);
      @(posedge clk); #1;
      check("rst_held", actual(), rv);
      rst = 1'b0;
      run(legal[1], 4, 2);

      run(7'b1111111, 2, 2);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      for (int c = 3; c <= 6; c++) begin
         Zero = 1'($urandom());
         q.push_back(model(7'b1111111, c, Zero));
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      rst = 1'b1;
      #1 check("trap_clear", actual(), rv);
      @(posedge clk); #1;
      rst = 1'b0;
`endif
      run(legal[5], 4, 2);
      run(legal[4], 3, 1);

      @(negedge clk); #1;
      n_checks++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending entries required 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameters: none; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op  input  7  opcode from instruction register; stable from Decode until return to Fetch.
REQ-005 Zero  input  1  ALU zero flag, valid in BEQ state.
REQ-006 PCWrite  output  1  PC load enable = PCUpdate | (Branch & Zero).
REQ-007 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 MemWrite  output  1  data memory write strobe.
REQ-009 IRWrite  output  1  instruction/OldPC register load.
REQ-010 RegWrite  output  1  register file write strobe.
REQ-011 ResultSrc  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 ALUSrcA  output  2  ALU operand A: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-013 ALUSrcB  output  2  ALU operand B: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
REQ-014 ALUOp  output  2  class code to the ALU decoder: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-015 ImmSrc  output  2  immediate format: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
REQ-016 Illegal  output  1  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only; tied 0 otherwise).

Function
REQ-017 Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL (+ TRAP when enabled); outputs are decoded from the state only, except PCWrite (uses Zero) and ImmSrc (uses op).
REQ-018 Unlisted outputs SHALL be 0 in every state.
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00.
- MEMADR and EXECUTEI: ALUSrcA 10, ALUSrcB 01; ALUOp 00 in MEMADR, 10 in EXECUTEI.
- EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
- MEMREAD: AdrSrc 1, ResultSrc 00.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1.
- MEMWB: ResultSrc 01, RegWrite 1.
- ALUWB: ResultSrc 00, RegWrite 1.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
REQ-019 Transitions:
- FETCH->DECODE unconditionally.
- DECODE on op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL.
- MEMADR: op 0000011->MEMREAD, otherwise MEMWRITE.
- MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB.
- MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
REQ-020 Instruction latency SHALL be: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
REQ-021 Any undecoded op in DECODE SHALL go to FETCH (no writes) when the trap is disabled.

Reset
REQ-022 rst high SHALL force the state to FETCH immediately and asynchronously, clear Illegal, and force PCWrite, IRWrite, RegWrite and MemWrite to 0 while asserted.
REQ-023 On the first rising edge after rst deasserts, the FSM SHALL execute FETCH; reset mid-instruction SHALL abandon that instruction with no further writes.

Configuration
REQ-024 Macro MAIN_FSM_ILLEGAL_TRAP_EN:
- Defined: undecoded op in DECODE->TRAP; TRAP asserts no strobes, holds until rst, and sets Illegal.
- Undefined: no TRAP state; behaviour per REQ-021.

Structure
REQ-025 Shared package SHALL hold the state enum, opcode constants and ALUOp/ResultSrc/ALUSrc encodings.
REQ-026 ImmSrc decode SHALL be a combinational sub-module, imm_src_decoder.

Verification
REQ-027 Reset: rst pulse mid-MEMWB -> state FETCH at once, RegWrite 0; next edge IRWrite 1, PCWrite 1.
REQ-028 lw: op 0000011 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite 1 only in cycle 5 with ResultSrc 01.
REQ-029 sw: op 0100011 -> MemWrite 1 only in cycle 4 with AdrSrc 1; ImmSrc 01.
REQ-030 beq: op 1100011 in BEQ with Zero 1 -> PCWrite 1, ALUOp 01; with Zero 0 -> PCWrite 0; back in FETCH next cycle.
REQ-031 R-type then jal: ALUOp 10 in EXECUTER; jal passes through JAL (PCWrite 1) then ALUWB (RegWrite 1); ImmSrc 11.
REQ-032 Illegal op 1111111: with trap -> TRAP held and Illegal 1 until rst; without trap -> FETCH after DECODE, no write strobe.
